// File: rtl/vedic_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_SIGNED_EN: two's-complement signed division truncating toward zero.
// Without it, operands and results are unsigned and no sign logic exists.
module vedic_seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH:0]     rem, rem_n;
  logic [WIDTH-1:0]   quo, quo_n;
  logic [WIDTH-1:0]   dsr, dsr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               in_ready_n, out_valid_n, dbz_n;
  logic [WIDTH-1:0]   quotient_n, remainder_n;

  logic [WIDTH+1:0]   rem_sh, trial;
  logic               trial_ok;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_q_n, neg_r, neg_r_n;
`endif

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    quo_n       = quo;
    dsr_n       = dsr;
    cnt_n       = cnt;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    quotient_n  = quotient;
    remainder_n = remainder;
    dbz_n       = div_by_zero;
`ifdef DIV_SIGNED_EN
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    a_mag       = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag       = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    a_mag       = dividend;
    b_mag       = divisor;
`endif

    // One restoring step: shift {rem,quo} left, subtract divisor, keep if non-negative
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - (WIDTH+2)'(dsr);
    trial_ok = ~trial[WIDTH+1];
    rem_step = trial_ok ? trial[WIDTH:0] : rem_sh[WIDTH:0];
    quo_step = {quo[WIDTH-2:0], trial_ok};

    q_fix = quo_step;
    r_fix = rem_step[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    if (neg_q) q_fix = -quo_step;
    if (neg_r) r_fix = -rem_step[WIDTH-1:0];
`endif

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          in_ready_n = 1'b0;
          if (divisor == '0) begin
            // Result is known immediately; out_valid rises one cycle later in DONE
            state_n     = S_DONE;
            quotient_n  = '1;
            remainder_n = dividend;
            dbz_n       = 1'b1;
          end else begin
            state_n = S_CALC;
            rem_n   = '0;
            quo_n   = a_mag;
            dsr_n   = b_mag;
            cnt_n   = CNT_W'(WIDTH - 1);
            dbz_n   = 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_n = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_n = dividend[WIDTH-1];
`endif
          end
        end
      end
      S_CALC: begin
        rem_n = rem_step;
        quo_n = quo_step;
        if (cnt == '0) begin
          state_n     = S_DONE;
          out_valid_n = 1'b1;
          quotient_n  = q_fix;
          remainder_n = r_fix;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_valid && out_ready) begin
          state_n     = S_IDLE;
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
        end else begin
          out_valid_n = 1'b1;
        end
      end
      default: begin
        state_n     = S_IDLE;
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State, working registers and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      quo         <= quo_n;
      dsr         <= dsr_n;
      cnt         <= cnt_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= dbz_n;
`ifdef DIV_SIGNED_EN
      neg_q       <= neg_q_n;
      neg_r       <= neg_r_n;
`endif
    end
  end

endmodule
